cmul_axis: RTL and testbench
============================

// Module: cmul_axis
// PURPOSE
// - Parametrised, pipelined complex multiplier on AXI-stream for the dk_hdl DSP chain; next generation of the fixed 16-bit cmul.
// - Computes p = a*b or a*conj(b), multiplies by an unsigned gain and rounds to DATA_WIDTH.
// - Saturates the result and counts saturation events.
// - Full tvalid/tready backpressure; tlast travels with its sample.
// PARAMETERS
// - DATA_WIDTH   16  bits per I or Q component, signed Q1.(DATA_WIDTH-1)
// - SCALE_WIDTH  18  width of scale_val, unsigned
// - SCALE_FRAC   16  fractional bits of scale_val (1.0 = 2**SCALE_FRAC)
// - CNT_WIDTH    16  width of sat_count
// PORTS
// - clk        in   1               clock
// - reset      in   1               asynchronous, active-low reset
// - in_tdata   in   4*DATA_WIDTH    {a_i, a_q, b_i, b_q}, MSB first
// - in_tlast   in   1               end-of-packet marker
// - in_tvalid  in   1               input valid
// - in_tready  out  1               input ready
// - conj_b     in   1               1: a*conj(b); 0: a*b; sampled with each accepted beat
// - scale_val  in   SCALE_WIDTH     gain; quasi-static, sampled with each accepted beat
// - out_tdata  out  2*DATA_WIDTH    {p_i, p_q}
// - out_tlast  out  1               tlast of the same sample
// - out_tvalid out  1               output valid
// - out_tready in   1               downstream ready
// - sat_clr    in   1               synchronous clear of sat_count
// - sat_count  out  CNT_WIDTH       saturating count of clipped output samples
// BEHAVIOUR
// - Reset (reset=0, asynchronous):
//   - all stage valids, out_tvalid, out_tdata, out_tlast and sat_count go to 0.
//   - In-flight samples are discarded.
// - Pipeline: 5 stages, each with a valid bit.
//   - S1: register a, b, conj_b, scale, tlast.
//   - S2: four real products.
//   - S3: re = ar*br -/+ ai*bi, im = ai*br +/- ar*bi (sign set by conj_b); 2*DATA_WIDTH+1 bits.
//   - S4: multiply by scale_val, zero-extended to signed.
//   - S5: round and saturate.
// - Latency: an accepted beat appears on out_* exactly 5 clk later when never stalled.
// - Handshake:
//   - en = !out_tvalid | out_tready; all stages advance when en=1, and all hold when en=0.
//   - in_tready = en; this is a combinational path, documented for integration.
//   - Beat accepted when in_tvalid & in_tready.
//   - Bubbles advance as invalid stages; no collapse is required.
//   - out_tdata and out_tlast are stable while out_tvalid=1 and out_tready=0.
// - Arithmetic:
//   - Result = round_half_up(prod*scale / 2**(DATA_WIDTH-1+SCALE_FRAC)).
//   - round_half_up: add 2**(shift-1), then arithmetic shift right.
//   - Saturation clamps to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1], independently on I and Q.
//   - Sample flagged saturated if I or Q clipped.
// - sat_count:
//   - Increments by 1 per flagged sample when it is accepted at S5 (en=1, valid); holds at all-ones.
//   - sat_clr has priority over a simultaneous increment; count becomes 0.
// - conj_b and scale_val changes apply from the next accepted beat; in-flight samples keep their values.
// STRUCTURE
// - cmul_pkg:
//   - localparam PIPE_DEPTH=5.
//   - Function sat_round(value, shift, out_width) shared with other dk_hdl arithmetic blocks.
// - Sub-module cmul_round_sat (S5): rounding, saturation and sat flag for one component, instantiated twice (I, Q).
// - Top holds the stage registers, valid chain, enable logic and sat counter.
// TESTING
// - Directed cases (all with DATA_WIDTH=16, scale=0x10000 unless stated):
//   - a=(0x4000,0), b=(0x4000,0), conj_b=0 -> out (0x2000,0x0000) exactly 5 clk after accept.
//   - a=(0,0x4000), b=(0,0x4000): conj_b=1 -> (0x2000,0); conj_b=0 -> (0xE000,0).
//   - a=(0x8000,0), b=(0x8000,0) -> (0x7FFF,0); sat_count 0->1.
//   - Then sat_clr pulse -> sat_count=0.
//   - Rounding: a=(1,0), b=(0x4000,0) -> (1,0); a=(0xFFFF,0), b=(0x4000,0) -> (0,0).
//   - Scale: a=(0x4000,0), b=(0x4000,0), scale=0x8000 -> (0x1000,0).
// - Stress and reset:
//   - 2000 random beats, random tlast, out_tready toggled 50% random -> matches bit-exact model.
//     Outputs in order, no drop or duplicate, tlast aligned; data stable while stalled.
//   - Pull reset low with 3 samples in flight -> out_tvalid=0 immediately, sat_count=0.
//     First output after release equals the model for the first post-reset input.

Source files
------------

// File: rtl/cmul_pkg.sv
// Shared constants and fixed-point helpers for the dk_hdl complex multiplier family.
// sat_round works on a wide signed container so one function serves any operand width.
package cmul_pkg;

    localparam int PIPE_DEPTH = 5;
    localparam int SR_W       = 128;

    typedef struct packed {
        logic                   sat;
        logic signed [SR_W-1:0] value;
    } sat_round_t;

    // Round half up by 'shift' bits, then clamp to a signed 'out_width' range.
    function automatic sat_round_t sat_round(input logic signed [SR_W-1:0] value,
                                             input int shift,
                                             input int out_width);
        sat_round_t             res;
        logic signed [SR_W-1:0] one;
        logic signed [SR_W-1:0] rounded;
        logic signed [SR_W-1:0] max_v;
        logic signed [SR_W-1:0] min_v;
        one     = {{(SR_W-1){1'b0}}, 1'b1};
        rounded = (value + (one <<< (shift - 1))) >>> shift;
        max_v   = (one <<< (out_width - 1)) - one;
        min_v   = -(one <<< (out_width - 1));
        res.sat = (rounded > max_v) || (rounded < min_v);
        if (rounded > max_v)
            res.value = max_v;
        else if (rounded < min_v)
            res.value = min_v;
        else
            res.value = rounded;
        return res;
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Final-stage rounding and saturation for one component (I or Q) of the product.
// Purely combinational; the top registers the result as the output stage.
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int IN_W  = 52,
    parameter int SHIFT = 31,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  value,
    output logic        [OUT_W-1:0] result,
    output logic                    sat
);

    sat_round_t             r;
    logic signed [SR_W-1:0] v;

    always_comb begin
        r      = sat_round(SR_W'(value), SHIFT, OUT_W);
        v      = r.value;
        result = v[OUT_W-1:0];
        // Anything not representable in OUT_W bits is treated as clipped as well.
        sat    = r.sat | (v[SR_W-1:OUT_W-1] != {(SR_W-OUT_W+1){v[OUT_W-1]}});
    end

endmodule

// File: rtl/cmul_axis.sv
// Pipelined AXI-stream complex multiplier: p = a*b or a*conj(b), scaled, rounded, saturated.
// One global enable stalls all five stages together; bubbles travel as invalid stages.
module cmul_axis
    import cmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SCALE_WIDTH = 18,
    parameter int SCALE_FRAC  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tlast,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    conj_b,
    input  logic [SCALE_WIDTH-1:0]  scale_val,
    output logic [2*DATA_WIDTH-1:0] out_tdata,
    output logic                    out_tlast,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    input  logic                    sat_clr,
    output logic [CNT_WIDTH-1:0]    sat_count
);

    localparam int DW    = DATA_WIDTH;
    localparam int PP_W  = 2 * DW;
    localparam int SUM_W = 2 * DW + 1;
    localparam int PRE_W = SUM_W + SCALE_WIDTH + 1;
    localparam int SHIFT = DW - 1 + SCALE_FRAC;

    logic                    en;
    logic [PIPE_DEPTH-1:0]   valid_reg;
    logic [PIPE_DEPTH-1:0]   last_reg;
    logic [2*DW-1:0]         out_tdata_reg;
    logic [CNT_WIDTH-1:0]    sat_count_reg;

    logic signed [DW-1:0]    a_i_reg, a_q_reg, b_i_reg, b_q_reg;
    logic [1:0]              conj_reg;
    logic [SCALE_WIDTH-1:0]  scale_reg [3];
    logic signed [PP_W-1:0]  rr_reg, ii_reg, ir_reg, ri_reg;
    logic signed [SUM_W-1:0] re_reg, im_reg;
    logic signed [PRE_W-1:0] pre_reg [2];
    logic [DW-1:0]           res [2];
    logic [1:0]              sat_flag;
    logic signed [PRE_W-1:0] scale_ext;

    // Combinational ready path: downstream ready reaches in_tready directly.
    assign en         = !out_tvalid | out_tready;
    assign in_tready  = en;
    assign out_tvalid = valid_reg[PIPE_DEPTH-1];
    assign out_tlast  = last_reg[PIPE_DEPTH-1];
    assign out_tdata  = out_tdata_reg;
    assign sat_count  = sat_count_reg;
    assign scale_ext  = PRE_W'($signed({1'b0, scale_reg[2]}));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg     <= '0;
            last_reg      <= '0;
            out_tdata_reg <= '0;
        end else if (en) begin
            valid_reg     <= {valid_reg[PIPE_DEPTH-2:0], in_tvalid};
            last_reg      <= {last_reg[PIPE_DEPTH-2:0], in_tlast};
            out_tdata_reg <= {res[0], res[1]};
        end
    end

    // Datapath carries no reset; its contents only matter where the valid chain says so.
    always_ff @(posedge clk) begin
        if (en) begin
            a_i_reg      <= in_tdata[4*DW-1:3*DW];
            a_q_reg      <= in_tdata[3*DW-1:2*DW];
            b_i_reg      <= in_tdata[2*DW-1:DW];
            b_q_reg      <= in_tdata[DW-1:0];
            conj_reg     <= {conj_reg[0], conj_b};
            scale_reg[0] <= scale_val;
            scale_reg[1] <= scale_reg[0];
            scale_reg[2] <= scale_reg[1];

            rr_reg <= PP_W'(a_i_reg) * PP_W'(b_i_reg);
            ii_reg <= PP_W'(a_q_reg) * PP_W'(b_q_reg);
            ir_reg <= PP_W'(a_q_reg) * PP_W'(b_i_reg);
            ri_reg <= PP_W'(a_i_reg) * PP_W'(b_q_reg);

            if (conj_reg[1]) begin
                re_reg <= SUM_W'(rr_reg) + SUM_W'(ii_reg);
                im_reg <= SUM_W'(ir_reg) - SUM_W'(ri_reg);
            end else begin
                re_reg <= SUM_W'(rr_reg) - SUM_W'(ii_reg);
                im_reg <= SUM_W'(ir_reg) + SUM_W'(ri_reg);
            end

            pre_reg[0] <= PRE_W'(re_reg) * scale_ext;
            pre_reg[1] <= PRE_W'(im_reg) * scale_ext;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_round
            cmul_round_sat #(
                .IN_W  (PRE_W),
                .SHIFT (SHIFT),
                .OUT_W (DW)
            ) u_round_sat (
                .value  (pre_reg[gi]),
                .result (res[gi]),
                .sat    (sat_flag[gi])
            );
        end
    endgenerate

    // Counts a clipped sample as it loads into the output stage; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sat_count_reg <= '0;
        else if (sat_clr)
            sat_count_reg <= '0;
        else if (en && valid_reg[PIPE_DEPTH-2] && (|sat_flag) && (sat_count_reg != '1))
            sat_count_reg <= sat_count_reg + 1'b1;
    end

endmodule

// File: tb/tb_cmul_axis.sv
// Scoreboard bench for cmul_axis: driver pushes expected beats, monitor pops on each output handshake.
// Covers directed arithmetic cases, random backpressure stress and mid-flight asynchronous reset.
module tb_cmul_axis;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_tdata;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic        conj_b;
    logic [17:0] scale_val;
    logic [31:0] out_tdata;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic        sat_clr;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    cmul_axis dut (
        .clk        (clk),
        .reset      (reset),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .conj_b     (conj_b),
        .scale_val  (scale_val),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .sat_clr    (sat_clr),
        .sat_count  (sat_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          drv_cyc;
        bit          lat_chk;
    } exp_t;

    typedef struct {
        logic [15:0] ai, aq, bi, bq;
        bit          cj;
        logic [17:0] sc;
        bit          lst;
        logic [31:0] expv;
    } vec_t;

    exp_t exp_q[$];
    vec_t dir_v[8];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   beat_no = 0;
    int   model_sat = 0;
    bit   rnd_ready = 0;

    always @(posedge clk) cyc++;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic longint rnd_sat(input longint x, output bit s);
        longint r;
        r = (x + (64'sd1 <<< 30)) >>> 31;
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [15:0] ai, aq, bi, bq,
                                          input bit cj, input logic [17:0] sc,
                                          output bit sat);
        longint ar, aim, br, bim, s, re, im, pi, pq;
        bit si, sq;
        ar  = longint'($signed(ai));
        aim = longint'($signed(aq));
        br  = longint'($signed(bi));
        bim = longint'($signed(bq));
        s   = longint'(sc);
        re  = cj ? ar * br + aim * bim : ar * br - aim * bim;
        im  = cj ? aim * br - ar * bim : aim * br + ar * bim;
        pi  = rnd_sat(re * s, si);
        pq  = rnd_sat(im * s, sq);
        sat = si | sq;
        return {pi[15:0], pq[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present one beat and hold it until accepted; push its expected output.
    task automatic issue(input logic [15:0] ai, aq, bi, bq, input bit cj,
                         input logic [17:0] sc, input bit lst,
                         input bit use_hand, input logic [31:0] hand, input bit lat);
        bit          s;
        logic [31:0] m;
        int          guard;
        exp_t        e;
        guard = 0;
        @(negedge clk);
        in_tdata  = {ai, aq, bi, bq};
        in_tvalid = 1'b1;
        in_tlast  = lst;
        conj_b    = cj;
        scale_val = sc;
        forever begin
            out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_tready) break;
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_tready stayed 0 for %0d cycles", guard);
                return;
            end
            @(negedge clk);
        end
        m = model(ai, aq, bi, bq, cj, sc, s);
        e.data    = use_hand ? hand : m;
        e.last    = lst;
        e.drv_cyc = cyc;
        e.lat_chk = lat;
        exp_q.push_back(e);
        if (!use_hand && s) model_sat++;
    endtask

    task automatic idle();
        @(negedge clk);
        in_tvalid  = 1'b0;
        in_tdata   = {$urandom, $urandom};
        out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            in_tvalid  = 1'b0;
            out_tready = 1'b1;
            #3;
            n++;
        end while ((exp_q.size() != 0 || out_tvalid) && n < budget);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compares every output handshake and checks stability while stalled.
    initial begin
        bit          holding;
        logic [31:0] held_d;
        logic        held_l;
        exp_t        e;
        holding = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset !== 1'b1) begin
                holding = 0;
            end else begin
                if (holding) begin
                    checks++;
                    if (!out_tvalid || out_tdata !== held_d || out_tlast !== held_l) begin
                        errors++;
                        $display("FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                 out_tvalid, out_tdata, out_tlast, held_d, held_l);
                    end
                end
                if (out_tvalid && out_tready) begin
                    holding = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got d=%h l=%b expected none", out_tdata, out_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        beat_no++;
                        if (out_tdata !== e.data || out_tlast !== e.last) begin
                            errors++;
                            $display("FAIL beat %0d: got d=%h l=%b expected d=%h l=%b",
                                     beat_no, out_tdata, out_tlast, e.data, e.last);
                        end else begin
                            $display("beat %0d d=%h l=%b ok", beat_no, out_tdata, out_tlast);
                        end
                        if (e.lat_chk) begin
                            checks++;
                            if (cyc - e.drv_cyc != 5) begin
                                errors++;
                                $display("FAIL latency beat %0d: got %0d expected 5", beat_no, cyc - e.drv_cyc);
                            end
                        end
                    end
                end else if (out_tvalid) begin
                    holding = 1;
                    held_d  = out_tdata;
                    held_l  = out_tlast;
                end else begin
                    holding = 0;
                end
            end
        end
    end

    initial begin
        dir_v[0] = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 18'h10000, 1'b0, 32'h2000_0000};
        dir_v[1] = '{16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b1, 18'h10000, 1'b1, 32'h2000_0000};
        dir_v[2] = '{16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0, 18'h10000, 1'b0, 32'hE000_0000};
        dir_v[3] = '{16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 18'h10000, 1'b0, 32'h0001_0000};
        dir_v[4] = '{16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 18'h10000, 1'b1, 32'h0000_0000};
        dir_v[5] = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 18'h08000, 1'b0, 32'h1000_0000};
        dir_v[6] = '{16'h4000, 16'h2000, 16'h2000, 16'h4000, 1'b0, 18'h10000, 1'b0, 32'h0000_2800};
        dir_v[7] = '{16'h4000, 16'h2000, 16'h2000, 16'h4000, 1'b1, 18'h10000, 1'b1, 32'h2000_E800};

        reset      = 1'b0;
        in_tdata   = '0;
        in_tlast   = 1'b0;
        in_tvalid  = 1'b0;
        conj_b     = 1'b0;
        scale_val  = 18'h10000;
        out_tready = 1'b1;
        sat_clr    = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("reset_out_tdata", 64'(out_tdata), 64'd0);
        chk("reset_out_tlast", 64'(out_tlast), 64'd0);
        chk("reset_sat_count", 64'(sat_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++)
            issue(dir_v[i].ai, dir_v[i].aq, dir_v[i].bi, dir_v[i].bq, dir_v[i].cj,
                  dir_v[i].sc, dir_v[i].lst, 1'b1, dir_v[i].expv, 1'b1);
        drain(50);
        chk("sat_count_before_sat", 64'(sat_count), 64'd0);

        issue(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 18'h10000, 1'b1, 1'b1, 32'h7FFF_0000, 1'b1);
        drain(50);
        chk("sat_count_after_sat", 64'(sat_count), 64'd1);

        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #3;
        chk("sat_clr", 64'(sat_count), 64'd0);

        // Q-only clip, with sat_clr raised for the exact edge the sample loads into S5.
        issue(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 18'h10000, 1'b0, 1'b1, 32'h0000_7FFF, 1'b1);
        repeat (3) idle();
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #3;
        chk("sat_clr_priority", 64'(sat_count), 64'd0);
        drain(50);

        rnd_ready = 1;
        model_sat = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            issue(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 18'($urandom), 1'($urandom_range(0, 1)),
                  1'b0, 32'h0, 1'b0);
        end
        rnd_ready = 0;
        drain(200);
        chk("sat_count_random", 64'(sat_count), 64'(model_sat > 65535 ? 65535 : model_sat));

        // Mid-flight reset: one sample on the output, two more behind it.
        issue(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 18'h10000, 1'b0, 1'b1, 32'h7FFF_0000, 1'b0);
        drain(50);
        issue(16'h1234, 16'h4321, 16'h7000, 16'h9000, 1'b0, 18'h10000, 1'b0, 1'b0, 32'h0, 1'b0);
        issue(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 18'h10000, 1'b1, 1'b0, 32'h0, 1'b0);
        issue(16'h2222, 16'hDDDD, 16'h3333, 16'hCCCC, 1'b1, 18'h10000, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        in_tvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_out_tvalid", 64'(out_tvalid), 64'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("async_reset_sat_count", 64'(sat_count), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        issue(16'h5A5A, 16'hA5A5, 16'h3C3C, 16'hC3C3, 1'b1, 18'h0C000, 1'b1, 1'b0, 32'h0, 1'b1);
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
